sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_arb_pick.sv | 57 +++++
 rtl/sram_port_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: response-owner states and host indices.
package sram_arb_pkg;

   // Owner of the response returned in the current cycle
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_I = 2'd1,
      RESP_D = 2'd2
   } owner_e;

   // Bit positions of each host in the request/grant vectors
   localparam logic HOST_I = 1'b0;
   localparam logic HOST_D = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selection between the fetch and load/store hosts.
// Default: data wins conflicts until instr has waited StarveLimit data grants.
// With SRAM_ARB_ROUND_ROBIN_EN defined: conflicts go to the host not granted last.
module sram_arb_pick
   import sram_arb_pkg::*;
#(
   parameter int unsigned StarveLimit = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic ptr;  // host favoured on the next conflict

   // Grant the sole requester, or the favoured host on a conflict
   always_comb begin
      gnt = 2'b00;
      if (!rst_i) begin
         if (req[HOST_I] && req[HOST_D]) gnt[ptr] = 1'b1;
         else                            gnt      = req;
      end
   end

   // Favour the other host after every grant
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)            ptr <= HOST_D;
      else if (gnt[HOST_I]) ptr <= HOST_D;
      else if (gnt[HOST_D]) ptr <= HOST_I;
   end
`else
   logic [3:0] starve;  // consecutive data grants while instr waits

   // Data has priority unless instr has been starved for StarveLimit grants
   always_comb begin
      gnt = 2'b00;
      if (!rst_i) begin
         if (req[HOST_I] && req[HOST_D]) begin
            if (starve == 4'(StarveLimit)) gnt[HOST_I] = 1'b1;
            else                           gnt[HOST_D] = 1'b1;
         end else begin
            gnt = req;
         end
      end
   end

   // Count data grants made while instr is waiting; any instr grant or idle instr clears it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                              starve <= 4'd0;
      else if (!req[HOST_I] || gnt[HOST_I])   starve <= 4'd0;
      else if (gnt[HOST_D])                   starve <= starve + 4'd1;
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-host arbiter (read-only fetch + load/store) in front of a single-port
// 1-cycle-latency SRAM. Out-of-window accesses never reach the RAM and come
// back with err=1. Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin
// conflict resolution instead of data priority with starvation limit.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned MemSize     = 65536,
   parameter logic [31:0] MemStart    = 32'h00000000,
   parameter int unsigned StarveLimit = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          instr_req_i,
   input  logic [31:0]                   instr_addr_i,
   output logic                          instr_gnt_o,
   output logic                          instr_rvalid_o,
   output logic [31:0]                   instr_rdata_o,
   output logic                          instr_err_o,
   input  logic                          data_req_i,
   input  logic                          data_we_i,
   input  logic [3:0]                    data_be_i,
   input  logic [31:0]                   data_addr_i,
   input  logic [31:0]                   data_wdata_i,
   output logic                          data_gnt_o,
   output logic                          data_rvalid_o,
   output logic [31:0]                   data_rdata_o,
   output logic                          data_err_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [3:0]                    mem_be_o,
   output logic [$clog2(MemSize)-3:0]    mem_addr_o,
   output logic [31:0]                   mem_wdata_o,
   input  logic [31:0]                   mem_rdata_i
);

   localparam int unsigned BW = $clog2(MemSize);

   logic [1:0]  req, gnt;
   logic [31:0] off_i, off_d, off;
   logic        in_i, in_d, in_sel, sel_d;
   owner_e      state, state_nxt;
   logic        err_q, err_nxt;
   logic        unused_off;

   assign req[HOST_I] = instr_req_i;
   assign req[HOST_D] = data_req_i;

   sram_arb_pick #(.StarveLimit(StarveLimit)) u_pick (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req   (req),
      .gnt   (gnt)
   );

   // Window offsets; unsigned wrap makes addresses below MemStart out of range
   assign off_i  = instr_addr_i - MemStart;
   assign off_d  = data_addr_i - MemStart;
   assign in_i   = off_i < 32'(MemSize);
   assign in_d   = off_d < 32'(MemSize);
   assign sel_d  = gnt[HOST_D];
   assign off    = sel_d ? off_d : off_i;
   assign in_sel = sel_d ? in_d : in_i;
   assign unused_off = ^{off[31:BW], off[1:0]};

   // Response owner register; reset drops any in-flight response
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
      end
   end

   // Next owner is whoever is granted now, remembering whether it missed the window
   always_comb begin
      state_nxt = IDLE;
      err_nxt   = 1'b0;
      if (gnt[HOST_I]) begin
         state_nxt = RESP_I;
         err_nxt   = !in_i;
      end else if (gnt[HOST_D]) begin
         state_nxt = RESP_D;
         err_nxt   = !in_d;
      end
   end

   // Drive RAM port from the granted host and route the response to its owner
   always_comb begin
      instr_gnt_o    = gnt[HOST_I];
      data_gnt_o     = gnt[HOST_D];
      mem_req_o      = (|gnt) && in_sel;
      mem_we_o       = mem_req_o && sel_d && data_we_i;
      mem_be_o       = !mem_req_o ? 4'h0 : (sel_d ? data_be_i : 4'hF);
      mem_wdata_o    = (mem_req_o && sel_d) ? data_wdata_i : 32'h0;
      mem_addr_o     = off[BW-1:2];
      instr_rvalid_o = (state == RESP_I);
      data_rvalid_o  = (state == RESP_D);
      instr_err_o    = instr_rvalid_o && err_q;
      data_err_o     = data_rvalid_o && err_q;
      instr_rdata_o  = (instr_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
      data_rdata_o   = (data_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
   end

endmodule
